// File: rtl/edid_ddc_pkg.sv
// rtl/edid_ddc_pkg.sv - shared types and constants for the EDID DDC responder
package edid_ddc_pkg;

  localparam logic [6:0] DDC_EDID_ADDR = 7'h50;
  localparam logic [6:0] DDC_SEG_ADDR  = 7'h30;
  localparam int         BYTE_BITS     = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WORD,
    ST_WORD_ACK,
    ST_WDISC,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT
  } ddc_state_t;

endpackage

// File: rtl/ddc_line_conditioner.sv
// rtl/ddc_line_conditioner.sv - SCL/SDA synchronizer, stability filter and bus event decoder
module ddc_line_conditioner #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0]            scl_sync;
  logic [1:0]            sda_sync;
  logic [FILTER_LEN-1:0] scl_hist;
  logic [FILTER_LEN-1:0] sda_hist;
  logic                  scl_q;
  logic                  sda_q;

  // Lines idle high, so everything resets to 1 to avoid a false event after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/edid_ddc_responder.sv
// rtl/edid_ddc_responder.sv - DDC target serving EDID bytes from a synchronous byte memory
// EDID_EDDC_SEGMENT_EN adds the E-DDC segment pointer at 0x30 and widens mem_addr to {seg, ptr}.
module edid_ddc_responder
  import edid_ddc_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DDC_EDID_ADDR,
  parameter int         FILTER_LEN = 4,
  parameter int         ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
`ifdef EDID_EDDC_SEGMENT_EN
  output logic [ADDR_WIDTH+6:0] mem_addr,
`else
  output logic [ADDR_WIDTH-1:0] mem_addr,
`endif
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  localparam logic [3:0] LAST_BIT  = 4'(BYTE_BITS - 1);
  localparam logic [3:0] FULL_BYTE = 4'(BYTE_BITS);

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  logic unused_scl_f;

  ddc_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_f    (scl_f),
    .sda_f    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign unused_scl_f = scl_f;

  ddc_state_t            state;
  logic [7:0]            shreg;
  logic [3:0]            bit_cnt;
  logic                  ack_phase;
  logic                  rw;
  logic                  ld_pend;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            rx_byte;

  assign rx_byte = {shreg[6:0], sda_f};

`ifdef EDID_EDDC_SEGMENT_EN
  logic [6:0] seg;
  logic       is_seg;
  assign mem_addr = {seg, ptr};
`else
  assign mem_addr = ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sda_oe    <= 1'b0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
      ld_pend   <= 1'b0;
      ptr       <= '0;
`ifdef EDID_EDDC_SEGMENT_EN
      seg       <= '0;
      is_seg    <= 1'b0;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      ld_pend   <= mem_rd_en;
      if (ld_pend) shreg <= mem_rdata;

      if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
`ifdef EDID_EDDC_SEGMENT_EN
        seg    <= '0;
`endif
      end else if (start) begin
        state     <= ST_ADDR;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              rw        <= sda_f;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
`ifdef EDID_EDDC_SEGMENT_EN
                is_seg <= 1'b0;
              end else if (rx_byte == {DDC_SEG_ADDR, 1'b0}) begin
                state  <= ST_ADDR_ACK;
                busy   <= 1'b1;
                is_seg <= 1'b1;
`endif
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          // First fall after the byte opens the ACK slot, the next one closes it.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              if (rw) begin
                state   <= ST_TX;
                sda_oe  <= ~shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state   <= ST_WORD;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end
            end
          end else if (scl_rise && ack_phase && rw) begin
            mem_rd_en <= 1'b1;
          end
          ST_WORD, ST_WDISC: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              state     <= ST_WORD_ACK;
              if (state == ST_WORD) begin
`ifdef EDID_EDDC_SEGMENT_EN
                if (is_seg) seg <= rx_byte[6:0];
                else
`endif
                ptr <= ADDR_WIDTH'(rx_byte);
              end
            end
          end
          ST_WORD_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              state     <= ST_WDISC;
            end
          end
          ST_TX: if (scl_fall) begin
            if (bit_cnt == FULL_BYTE) begin
              sda_oe <= 1'b0;
              state  <= ST_TX_ACK;
            end else begin
              sda_oe  <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // Pointer only advances on a host ACK, so a NACK leaves it on the last byte sent.
          ST_TX_ACK: if (scl_rise) begin
            if (sda_f) begin
              state <= ST_WAIT;
              busy  <= 1'b0;
            end else begin
              ptr       <= ptr + ADDR_WIDTH'(1);
              mem_rd_en <= 1'b1;
              ack_phase <= 1'b1;
            end
          end else if (scl_fall && ack_phase) begin
            ack_phase <= 1'b0;
            state     <= ST_TX;
            sda_oe    <= ~shreg[7];
            shreg     <= {shreg[6:0], 1'b0};
            bit_cnt   <= 4'd1;
          end
          ST_IDLE, ST_WAIT: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edid_ddc_responder.sv
// tb/tb_edid_ddc_responder.sv - self-checking bench driving a bit-banged DDC host against a memory model
module tb_edid_ddc_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic host_low = 1'b0;
  logic sda_line;
  logic sda_oe, mem_rd_en, busy;
  logic [7:0] mem_rdata = 8'h00;
`ifdef EDID_EDDC_SEGMENT_EN
  logic [14:0] mem_addr;
`else
  logic [7:0] mem_addr;
`endif

  logic [7:0] mem [256];
  logic [7:0] model_ptr = 8'h00;
  int n_tests = 0;
  int n_fail = 0;
  int oe_cnt = 0;

  assign sda_line = ~(host_low | sda_oe);

  edid_ddc_responder dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
  always @(negedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period of 40 clocks; entered and left with SCL low.
  task automatic host_bit(input logic drive_low, input logic glitch, output logic sampled);
    tick(12); host_low = drive_low;
    tick(8);  scl = 1'b1;
    tick(5);
    if (glitch) begin scl = 1'b0; tick(2); scl = 1'b1; tick(3); end
    else tick(5);
    sampled = sda_line;
    tick(10); scl = 1'b0;
  endtask

  task automatic do_start;
    if (!scl) begin
      tick(12); host_low = 1'b0;
      tick(8);  scl = 1'b1;
      tick(10);
    end
    host_low = 1'b1; tick(10);
    scl = 1'b0;
  endtask

  task automatic do_stop;
    tick(12); host_low = 1'b1;
    tick(8);  scl = 1'b1;
    tick(10); host_low = 1'b0;
    tick(10);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) host_bit(~b[i], i == glitch_bit, s);
    host_bit(1'b0, 1'b0, nack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      host_bit(1'b0, 1'b0, s);
      d = {d[6:0], s};
    end
    host_bit(ack, 1'b0, s);
  endtask

  task automatic read_seq(input logic [7:0] off, input int len, input string name);
    logic nack;
    logic [7:0] d, exp_d;
    do_start;
    write_byte(8'hA0, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL %s addr_w_ack: got nack=%b want 0", name, nack); end
    write_byte(off, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL %s offset_ack: got nack=%b want 0", name, nack); end
    do_start;
    write_byte(8'hA1, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL %s addr_r_ack: got nack=%b want 0", name, nack); end
    for (int i = 0; i < len; i++) begin
      read_byte(i != len - 1, d);
      exp_d = mem[8'(off + i)];
      n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL %s data[%0d]: got %h want %h", name, i, d, exp_d); end
    end
    model_ptr = 8'(off + len - 1);
    n_tests++; if (mem_addr[7:0] !== model_ptr) begin n_fail++; $display("FAIL %s ptr: got %h want %h", name, mem_addr[7:0], model_ptr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_nack: got %b want 0", name, busy); end
    do_stop;
  endtask

  task automatic test_reset;
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_offset_read;
    logic nack;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    do_start;
    write_byte(8'hA0, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL offs_addr_ack: got %b want 0", nack); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL offs_busy_match: got %b want 1", busy); end
    write_byte(8'h10, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL offs_word_ack: got %b want 0", nack); end
    do_start;
    write_byte(8'hA1, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL offs_read_ack: got %b want 0", nack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i != 2, d);
      n_tests++; if (d !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL offs_data[%0d]: got %h want %h", i, d, 8'(8'h11 + i)); end
    end
    n_tests++; if (mem_addr[7:0] !== 8'h12) begin n_fail++; $display("FAIL offs_ptr_end: got %h want 12", mem_addr[7:0]); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL offs_busy_nack: got %b want 0", busy); end
    model_ptr = 8'h12;
    do_stop;
  endtask

  task automatic test_wrong_addr;
    logic nack;
    int oe_before;
    oe_before = oe_cnt;
    do_start;
    write_byte(8'hA2, -1, nack);
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_ack: got nack=%b want 1", nack); end
    write_byte(8'($urandom), -1, nack);
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_data_ack: got nack=%b want 1", nack); end
    n_tests++; if (oe_cnt !== oe_before) begin n_fail++; $display("FAIL wrong_addr_oe: got %0d drive cycles want 0", oe_cnt - oe_before); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b want 0", busy); end
    do_stop;
  endtask

  task automatic test_pointer_wrap;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    read_seq(8'hFF, 2, "wrap");
  endtask

  task automatic test_random_reads;
    logic nack;
    logic [7:0] d, exp_d;
    for (int k = 0; k < 4; k++) begin
      read_seq(8'($urandom), int'($urandom_range(1, 4)), "rand");
      do_start;
      write_byte(8'hA1, -1, nack);
      n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL cur_read_ack: got %b want 0", nack); end
      read_byte(1'b0, d);
      exp_d = mem[model_ptr];
      n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL cur_read_data: got %h want %h", d, exp_d); end
      do_stop;
    end
  endtask

  task automatic test_glitch;
    logic nack;
    do_start;
    write_byte(8'hA0, 4, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL glitch_scl_ack: got nack=%b want 0", nack); end
    write_byte(8'h5A, 2, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL glitch_word_ack: got nack=%b want 0", nack); end
    n_tests++; if (mem_addr[7:0] !== 8'h5A) begin n_fail++; $display("FAIL glitch_word_ptr: got %h want 5a", mem_addr[7:0]); end
    model_ptr = 8'h5A;
    do_stop;
    tick(10);
    host_low = 1'b1; tick(2); host_low = 1'b0;
    tick(20);
    scl = 1'b0;
    write_byte(8'hA0, -1, nack);
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL glitch_sda_no_start: got nack=%b want 1", nack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_sda_busy: got %b want 0", busy); end
    do_stop;
  endtask

  task automatic test_stop_mid_read;
    logic nack, s;
    logic [7:0] p, d;
    logic [3:0] hi;
    p = 8'($urandom);
    mem[p] = mem[p] | 8'h08;
    do_start;
    write_byte(8'hA0, -1, nack);
    write_byte(p, -1, nack);
    do_start;
    write_byte(8'hA1, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL stopmid_ack: got %b want 0", nack); end
    hi = 4'h0;
    for (int i = 0; i < 4; i++) begin
      host_bit(1'b0, 1'b0, s);
      hi = {hi[2:0], s};
    end
    n_tests++; if (hi !== mem[p][7:4]) begin n_fail++; $display("FAIL stopmid_bits: got %h want %h", hi, mem[p][7:4]); end
    do_stop;
    n_tests++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stopmid_release: got oe=%b busy=%b want 0 0", sda_oe, busy); end
    do_start;
    write_byte(8'hA1, -1, nack);
    read_byte(1'b0, d);
    n_tests++; if (d !== mem[p]) begin n_fail++; $display("FAIL stopmid_resume: got %h want %h", d, mem[p]); end
    do_stop;
  endtask

  task automatic test_async_reset;
    logic s;
    do_start;
    for (int i = 7; i >= 0; i--) host_bit(i == 0 ? 1'b1 : ~(8'hA0 >> i), 1'b0, s);
    host_low = 1'b0;
    tick(12);
    n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got oe=%b want 1", sda_oe); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got oe=%b want 0", sda_oe); end
    n_tests++; if (mem_addr !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: got addr=%h busy=%b want 0 0", mem_addr, busy); end
    tick(3);
    rst = 1'b0;
    model_ptr = 8'h00;
    do_stop;
  endtask

  task automatic test_segment;
    logic nack;
    logic [7:0] d;
    do_start;
    write_byte(8'h60, -1, nack);
`ifdef EDID_EDDC_SEGMENT_EN
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL seg_addr_ack: got %b want 0", nack); end
    write_byte(8'h01, -1, nack);
    do_start;
    write_byte(8'hA0, -1, nack);
    write_byte(8'h80, -1, nack);
    do_start;
    write_byte(8'hA1, -1, nack);
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL seg_read_ack: got %b want 0", nack); end
    read_byte(1'b0, d);
    n_tests++; if (d !== mem[8'h80]) begin n_fail++; $display("FAIL seg_data: got %h want %h", d, mem[8'h80]); end
    n_tests++; if (mem_addr !== 15'h180) begin n_fail++; $display("FAIL seg_mem_addr: got %h want 180", mem_addr); end
`else
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL seg_nack: got %b want 1", nack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seg_busy: got %b want 0", busy); end
    d = 8'h00;
`endif
    do_stop;
  endtask

  initial begin
    tick(3);
    test_reset;
    rst = 1'b0;
    tick(10);
    test_offset_read;
    test_wrong_addr;
    test_pointer_wrap;
    test_random_reads;
    test_glitch;
    test_stop_mid_read;
    test_async_reset;
    test_segment;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/edid_ddc_responder.md
Name: edid_ddc_responder

Overview:
- I2C/DDC target (monitor end) that answers EDID reads from a host at 7-bit device address DEV_ADDR (0x50).
- Accepts a word-offset write, then streams EDID bytes from an external synchronous byte memory with auto-increment.
- Sits behind the sink-side SCL/SDA pads, at the far end of the DDC pass-through bridge. Lets the team emulate a monitor and close the bridge loop in simulation and on board.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address; reads use 8'hA1, writes use 8'hA0.
- FILTER_LEN, 4, number of consecutive equal samples needed before a synchronized SCL/SDA level is accepted.
- ADDR_WIDTH, 8, width of the byte pointer and mem_addr.

Ports:
- clk  in  1  system clock; must be at least 20x the SCL rate.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- mem_addr  out  ADDR_WIDTH  byte pointer to the EDID memory.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the cycle after mem_rd_en.
- busy  out  1  high from an addressed-match ACK until STOP or a NACKed read.

Behaviour:
- Reset values: sda_oe=0, mem_rd_en=0, mem_addr=0, busy=0, state=IDLE. Reset asserted mid-transfer releases SDA immediately (asynchronous).
- Input path:
  - 2-FF synchronizer, then a FILTER_LEN stability filter.
  - Single-cycle scl_rise, scl_fall, start and stop events are taken from the filtered levels.
  - start = SDA fall while SCL high; stop = SDA rise while SCL high.
- SDA is changed only in the cycle after scl_fall. Bits are shifted in MSB first on scl_rise.
- States: IDLE, ADDR, ADDR_ACK, WORD, WORD_ACK, WDISC, TX, TX_ACK, WAIT.
  - IDLE --start--> ADDR.
  - ADDR: shift 8 bits.
    - On the 8th scl_rise, match = (byte[7:1]==DEV_ADDR).
    - No match -> WAIT with sda_oe kept 0.
    - Match -> ADDR_ACK.
  - ADDR_ACK:
    - sda_oe=1 from the 8th scl_fall to the 9th scl_fall.
    - R/W=0 -> WORD.
    - R/W=1 -> TX. mem_rd_en pulses at the 9th scl_rise; mem_rdata is latched into the shift register next cycle.
  - WORD: shift 8 bits, then load mem_addr; ACK in WORD_ACK, then go to WDISC.
  - WDISC: further written bytes are ACKed and discarded (the memory is read-only); the pointer is unchanged.
  - TX:
    - Drive sda_oe = ~bit on each scl_fall, MSB first.
    - After the 8th scl_fall, release SDA -> TX_ACK.
  - TX_ACK: sample SDA at the 9th scl_rise.
    - 0 (ACK): mem_addr+1, wrapping at 2^ADDR_WIDTH-1 -> 0. Pulse mem_rd_en, reload the shift register, back to TX.
    - 1 (NACK): -> WAIT, busy=0.
  - WAIT: sda_oe=0; ignore everything except start/stop.
- From any state:
  - start (repeated) -> ADDR; sda_oe released the same cycle; mem_addr retained.
  - stop -> IDLE; sda_oe=0.
  - If start and stop are both decoded in the same cycle, stop wins.
- mem_addr persists across transactions, so a read with no offset write continues from the last pointer (current-address read).

Optional Feature:
- Macro EDID_EDDC_SEGMENT_EN.
- When defined, the block also acknowledges a write to address 7'h30 (E-DDC segment pointer).
  - The data byte sets seg[6:0]; mem_addr widens to ADDR_WIDTH+7 bits as {seg, ptr}.
  - seg is cleared by stop and retained across repeated start.
  - Read wrap stays within the current 256-byte segment.
- When undefined, address 0x30 is treated as a non-match and mem_addr is ADDR_WIDTH bits.

Decomposition:
- Package edid_ddc_pkg: state enum; constants DDC_EDID_ADDR=7'h50, DDC_SEG_ADDR=7'h30, BYTE_BITS=8.
- One sub-module ddc_line_conditioner: synchronizer, FILTER_LEN filter and event generator. Outputs scl_f, sda_f, scl_rise, scl_fall, start, stop.

Test Plan:
- Offset write then read: A0, 10, Sr, A1, read 3 bytes (ACK, ACK, NACK), memory holds addr+1 -> returns 11,12,13; mem_addr ends at 0x12; busy falls after NACK.
- Wrong address: A2 (write to 0x51) -> sda_oe stays 0 through the 9th clock; subsequent bytes are ignored until stop.
- Pointer wrap: offset FF, read 2 bytes -> data from 0xFF then 0x00.
- Glitch rejection: a 2-clk low pulse on SCL mid-byte -> no bit shifted and no event. A 2-clk SDA dip with SCL high -> no start.
- Stop mid-read after 4 bits -> IDLE, sda_oe=0 within 1 cycle of the filtered stop; the next A1 read restarts from the retained pointer. rst asserted mid-ACK -> sda_oe=0 asynchronously.
- (EDID_EDDC_SEGMENT_EN) 60, 01, Sr, A0, 80, Sr, A1, read 1 byte -> mem_addr=0x180, byte ACKed; without the macro, 60 is NACKed.
